// File: rtl/rst_sync_seq.sv
// Reset synchroniser and sequencer: brings the async active-low RST into the
// CLK domain, filters it, then releases NUM_CH reset channels one after another.
module rst_sync_seq #(
    parameter int NUM_STAGES = 3,
    parameter int NUM_CH     = 4,
    parameter int FILT_CYC   = 4,
    parameter int STEP_DLY   = 8,
    parameter int SW_LEN     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SW_RST_REQ,
    output logic [NUM_CH-1:0] SYNC_RST,
    output logic              RST_DONE
);

    localparam int MAX_FS  = (FILT_CYC > SW_LEN) ? FILT_CYC : SW_LEN;
    localparam int MAX_CYC = (STEP_DLY > MAX_FS) ? STEP_DLY : MAX_FS;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0]  FILT_LAST = CNT_W'(FILT_CYC - 1);
    localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_DLY - 1);
    localparam logic [CNT_W-1:0]  SW_LAST   = CNT_W'(SW_LEN - 1);
    localparam logic [NUM_CH-1:0] CH0_ONLY  = NUM_CH'(1);

    typedef enum logic [2:0] {
        HOLD,
        FILTER,
        SEQ,
        RUN,
        SWRST
    } state_t;

    // Grows the released set by one channel while keeping it a thermometer code.
    function automatic logic [NUM_CH-1:0] next_therm(input logic [NUM_CH-1:0] cur);
        return (cur << 1) | CH0_ONLY;
    endfunction

    logic [NUM_STAGES-1:0] sync_p;
    logic                  sync_q;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [NUM_CH-1:0]     sync_rst_q;
    logic [NUM_CH-1:0]     sync_rst_d;
    logic                  rst_done_q;
    logic                  rst_done_d;
    logic [NUM_CH-1:0]     grown;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[NUM_STAGES-2:0], 1'b1};
        end
    end

    assign sync_q = sync_p[NUM_STAGES-1];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            sync_rst_q <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_rst_q <= sync_rst_d;
            rst_done_q <= rst_done_d;
        end
    end

    // Outputs are computed one edge ahead so that they leave the block straight from flops.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        sync_rst_d = sync_rst_q;
        rst_done_d = rst_done_q;
        grown      = next_therm(sync_rst_q);

        case (state_q)
            HOLD: begin
                cnt_d      = '0;
                sync_rst_d = '0;
                rst_done_d = 1'b0;
                if (sync_q) begin
                    state_d = FILTER;
                end
            end
            FILTER: begin
                if (cnt_q == FILT_LAST) begin
                    cnt_d      = '0;
                    sync_rst_d = CH0_ONLY;
                    if (NUM_CH == 1) begin
                        state_d    = RUN;
                        rst_done_d = 1'b1;
                    end else begin
                        state_d = SEQ;
                    end
                end
            end
            SEQ: begin
                if (cnt_q == STEP_LAST) begin
                    cnt_d      = '0;
                    sync_rst_d = grown;
                    if (&grown) begin
                        state_d    = RUN;
                        rst_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_d = '0;
                if (SW_RST_REQ) begin
                    state_d    = SWRST;
                    sync_rst_d = '0;
                    rst_done_d = 1'b0;
                end
            end
            SWRST: begin
                if (cnt_q == SW_LAST) begin
                    cnt_d      = '0;
                    sync_rst_d = CH0_ONLY;
                    if (NUM_CH == 1) begin
                        state_d    = RUN;
                        rst_done_d = 1'b1;
                    end else begin
                        state_d = SEQ;
                    end
                end
            end
            default: begin
                state_d    = HOLD;
                cnt_d      = '0;
                sync_rst_d = '0;
                rst_done_d = 1'b0;
            end
        endcase
    end

    assign SYNC_RST = sync_rst_q;
    assign RST_DONE = rst_done_q;

endmodule
